// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and one carry flop process
// the operands LSB first, one bit per clock, under an IDLE/RUN/DONE FSM.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit;
  logic             carry_out;

  // The single full-adder cell shared by every bit position.
  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Signed overflow: carry into the sign bit differs from carry out.
          cout_d  = carry_out;
          ovf_d   = carry_q ^ carry_out;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign Result = res_q;
  assign Cout   = cout_q;
  assign Ovf    = ovf_q;

endmodule
